bf_bus_ctrl: RTL and testbench

- Run controller and bus arbiter for the BF interpreter core.
- Sequences the core through clear, run and done phases using the core's reset and enable inputs.
- Maps the core's BusOp requests onto one single-port synchronous RAM (program and data regions) and onto valid/ready byte streams for IO.
- Shares the RAM with a host load/inspect port and stalls the core through its enable input whenever a request cannot complete this cycle.

---
 rtl/bf_pkg.sv | 28 ++
 rtl/bf_out_buf.sv | 36 +++
 rtl/bf_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bf_bus_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types for the BF run controller: core bus operations, controller
// states and RAM region selectors.
package bf_pkg;

  typedef enum logic [2:0] {
    BusNone      = 3'd0,
    BusReadProg  = 3'd1,
    BusReadData  = 3'd2,
    BusWriteData = 3'd3,
    BusReadIo    = 3'd4,
    BusWriteIo   = 3'd5
  } BusOp;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } CtrlState;

  localparam logic REGION_PROG = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  function automatic logic is_mem_read(BusOp op);
    return (op == BusReadProg) || (op == BusReadData);
  endfunction

endpackage

// File: rtl/bf_out_buf.sv
// One-entry valid/ready output buffer for the core's output byte stream.
// A push is only issued when the slot is empty or draining this cycle.
module bf_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/bf_bus_ctrl.sv
// Run controller and RAM/IO arbiter for the BF interpreter core.
// Define BF_HOST_SNOOP_EN to let the host access RAM while the core runs.
module bf_bus_ctrl
  import bf_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [1:0]            state_out,
  output logic                  core_reset,
  output logic                  core_enable,
  input  logic                  core_halted,
  input  BusOp                  core_bus_op,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [BUS_WIDTH-1:0]  core_val_out,
  output logic [BUS_WIDTH-1:0]  core_val_in,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH:0]   host_addr,
  input  logic [BUS_WIDTH-1:0]  host_wdata,
  output logic                  host_ack,
  output logic [BUS_WIDTH-1:0]  host_rdata,
  input  logic                  io_in_valid,
  input  logic [BUS_WIDTH-1:0]  io_in_data,
  output logic                  io_in_ready,
  output logic                  io_out_valid,
  output logic [BUS_WIDTH-1:0]  io_out_data,
  input  logic                  io_out_ready
);

  CtrlState             r_state;
  CtrlState             w_state_next;
  logic                 r_rd_pend;
  logic                 r_host_pend;
  logic [BUS_WIDTH-1:0] r_hold;

  logic w_run;
  logic w_host_allow;
  logic w_host_grant;
  logic w_stall;
  logic w_accept;
  logic w_push;
  logic w_mem_rd;

  assign w_run = (r_state == RUN);

`ifdef BF_HOST_SNOOP_EN
  assign w_host_allow = 1'b1;
`else
  assign w_host_allow = !w_run;
`endif

  // One host access at a time: the ack cycle still sees host_req held high.
  assign w_host_grant = host_req && !r_host_pend && w_host_allow && !reset;

  always_comb begin
    w_stall = w_host_grant;
    case (core_bus_op)
      BusReadIo:  if (!io_in_valid) w_stall = 1'b1;
      BusWriteIo: if (io_out_valid && !io_out_ready) w_stall = 1'b1;
      default:    ;
    endcase
  end

  assign core_enable = w_run && !w_stall;
  assign w_accept    = core_enable && (core_bus_op != BusNone);
  assign w_push      = w_accept && (core_bus_op == BusWriteIo);
  assign w_mem_rd    = w_accept && is_mem_read(core_bus_op);
  assign io_in_ready = w_accept && (core_bus_op == BusReadIo);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_host_grant) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
      mem_re    = !host_we;
    end else if (w_accept) begin
      case (core_bus_op)
        BusReadProg: begin
          mem_addr = {REGION_PROG, core_addr};
          mem_re   = 1'b1;
        end
        BusReadData: begin
          mem_addr = {REGION_DATA, core_addr};
          mem_re   = 1'b1;
        end
        BusWriteData: begin
          mem_addr  = {REGION_DATA, core_addr};
          mem_wdata = core_val_out;
          mem_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    core_reset   = 1'b1;
    case (r_state)
      IDLE: if (start) w_state_next = CLEAR;
      CLEAR: w_state_next = RUN;
      RUN: begin
        core_reset = 1'b0;
        if (abort)            w_state_next = IDLE;
        else if (core_halted) w_state_next = DONE;
      end
      DONE: begin
        core_reset = 1'b0;
        if (abort)      w_state_next = IDLE;
        else if (start) w_state_next = CLEAR;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rd_pend   <= 1'b0;
      r_host_pend <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rd_pend   <= w_mem_rd;
      r_host_pend <= w_host_grant;
      // An IO read accepted right after a RAM read is the newer value.
      if (io_in_ready)
        r_hold <= io_in_data;
      else if (r_rd_pend)
        r_hold <= mem_rdata;
    end
  end

  assign core_val_in = r_rd_pend ? mem_rdata : r_hold;
  assign state_out   = r_state;
  assign host_ack    = r_host_pend;
  assign host_rdata  = mem_rdata;

  bf_out_buf #(
    .WIDTH (BUS_WIDTH)
  ) u_out_buf (
    .clock   (clock),
    .reset   (reset),
    .i_flush (r_state == CLEAR),
    .i_push  (w_push),
    .i_data  (core_val_out),
    .i_ready (io_out_ready),
    .o_valid (io_out_valid),
    .o_data  (io_out_data)
  );

endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Self-checking bench for bf_bus_ctrl: directed run/stall/abort scenarios and
// a randomized core-op phase checked against a high-level memory/stream model.
module tb_bf_bus_ctrl;
  import bf_pkg::*;

  localparam int AW = 15;
  localparam int BW = 8;

  logic          clock = 1'b0;
  logic          reset, start, abort;
  logic [1:0]    state_out;
  logic          core_reset, core_enable, core_halted;
  BusOp          core_bus_op;
  logic [AW-1:0] core_addr;
  logic [BW-1:0] core_val_out, core_val_in;
  logic [AW:0]   mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic          host_req, host_we, host_ack;
  logic [AW:0]   host_addr;
  logic [BW-1:0] host_wdata, host_rdata;
  logic          io_in_valid, io_in_ready, io_out_valid, io_out_ready;
  logic [BW-1:0] io_in_data, io_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ram [0:65535];
  logic [7:0] prog_ref [0:7];
  logic [7:0] data_ref [0:15];
  logic [7:0] in_q[$];
  logic [7:0] in_stream[$];
  logic [7:0] exp_out[$];
  logic [7:0] out_got[$];
  logic       rand_env = 1'b0;
  logic       mon_en   = 1'b0;

  bf_bus_ctrl #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .state_out(state_out), .core_reset(core_reset), .core_enable(core_enable),
    .core_halted(core_halted), .core_bus_op(core_bus_op), .core_addr(core_addr),
    .core_val_out(core_val_out), .core_val_in(core_val_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .io_in_valid(io_in_valid), .io_in_data(io_in_data),
    .io_in_ready(io_in_ready), .io_out_valid(io_out_valid),
    .io_out_data(io_out_data), .io_out_ready(io_out_ready)
  );

  always #5 clock = ~clock;

  // Single-port synchronous RAM seen by the controller.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic env_step();
    io_in_valid  = (in_q.size() > 0) && ($urandom_range(0, 1) == 1);
    io_in_data   = (in_q.size() > 0) ? in_q[0] : 8'h00;
    io_out_ready = ($urandom_range(0, 1) == 1);
  endtask

  // Handshakes seen here are committed at the following rising edge.
  task automatic mon_step();
    if (io_in_valid && io_in_ready) void'(in_q.pop_front());
    if (io_out_valid && io_out_ready) out_got.push_back(io_out_data);
  endtask

  task automatic cyc();
    @(negedge clock);
    if (rand_env) env_step();
  endtask

  task automatic smp();
    #1;
    if (mon_en) mon_step();
  endtask

  task automatic core_op(input BusOp op, input logic [AW-1:0] addr, input logic [7:0] wd,
                         output logic [7:0] rd, output int waits);
    cyc();
    core_bus_op = op; core_addr = addr; core_val_out = wd;
    smp();
    waits = 0;
    while (!core_enable && waits < 200) begin
      cyc(); smp(); waits++;
    end
    check_eq("core_accept", core_enable, 1);
    cyc();
    core_bus_op = BusNone;
    smp();
    rd = core_val_in;
    $display("[TB] core op %0d addr %0h wd %0h -> rd %0h after %0d stall cycles", op, addr, wd, rd, waits);
  endtask

  task automatic host_access(input logic we, input logic [AW:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output int lat);
    cyc();
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    smp();
    lat = 0;
    while (!host_ack && lat < 50) begin
      cyc(); smp(); lat++;
    end
    check_eq("host_ack_seen", host_ack, 1);
    rd = host_rdata;
    cyc();
    host_req = 1'b0; host_we = 1'b0;
    smp();
    $display("[TB] host %s addr %0h wd %0h -> rd %0h latency %0d", we ? "wr" : "rd", addr, wd, rd, lat);
  endtask

  task automatic go_run();
    cyc(); start = 1'b1; smp();
    cyc(); start = 1'b0; smp();
    check_eq("clear_state", state_out, CLEAR);
    check_eq("clear_core_reset", core_reset, 1);
    check_eq("clear_core_enable", core_enable, 0);
    cyc(); smp();
    check_eq("run_state", state_out, RUN);
    check_eq("run_core_reset", core_reset, 0);
    $display("[TB] run started");
  endtask

  task automatic do_halt();
    cyc(); core_halted = 1'b1; smp();
    cyc(); core_halted = 1'b0; smp();
    check_eq("done_state", state_out, DONE);
    check_eq("done_core_enable", core_enable, 0);
    $display("[TB] core halted");
  endtask

  initial begin
    logic [7:0] rd;
    int         lat, cnt, acks, k;
    logic       saw_ready;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    reset = 1'b1; start = 1'b0; abort = 1'b0; core_halted = 1'b0;
    core_bus_op = BusNone; core_addr = '0; core_val_out = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    io_in_valid = 1'b0; io_in_data = '0; io_out_ready = 1'b0;

    // Reset state
    repeat (3) cyc();
    smp();
    check_eq("rst_state", state_out, IDLE);
    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_core_enable", core_enable, 0);
    check_eq("rst_mem_strobes", {mem_we, mem_re}, 0);
    check_eq("rst_host_ack", host_ack, 0);
    check_eq("rst_io", {io_in_ready, io_out_valid}, 0);
    check_eq("rst_val_in", core_val_in, 0);
    cyc(); reset = 1'b0; smp();

    // Host loads "+." and a terminator in IDLE, then reads them back
    prog_ref[0] = 8'h2B; prog_ref[1] = 8'h2E; prog_ref[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      host_access(1'b1, 16'(i), prog_ref[i], rd, lat);
      check_eq("host_wr_latency", lat, 1);
    end
    for (int i = 0; i < 3; i++) begin
      host_access(1'b0, 16'(i), 8'h00, rd, lat);
      check_eq("host_rd_data", rd, prog_ref[i]);
    end

    // Core executes "+." : fetch, increment cell 0, output it, halt
    go_run();
    core_op(BusReadProg, 15'd0, 8'h00, rd, lat);  check_eq("prog0", rd, 8'h2B);
    core_op(BusReadData, 15'd0, 8'h00, rd, lat);  check_eq("cell0_init", rd, 8'h00);
    core_op(BusWriteData, 15'd0, 8'h01, rd, lat);
    core_op(BusReadProg, 15'd1, 8'h00, rd, lat);  check_eq("prog1", rd, 8'h2E);
    core_op(BusReadData, 15'd0, 8'h00, rd, lat);  check_eq("cell0_inc", rd, 8'h01);
    core_op(BusWriteIo, 15'd0, 8'h01, rd, lat);
    check_eq("out_valid", io_out_valid, 1);
    check_eq("out_data", io_out_data, 8'h01);
    core_op(BusReadProg, 15'd2, 8'h00, rd, lat);  check_eq("prog2", rd, 8'h00);
    do_halt();
    cyc(); io_out_ready = 1'b1; smp();
    cyc(); io_out_ready = 1'b0; smp();
    check_eq("out_drained", io_out_valid, 0);

    // BusReadIo stalls until input is valid
    go_run();
    cyc(); core_bus_op = BusReadIo; io_in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (!core_enable && !io_in_ready) cnt++;
      cyc();
    end
    check_eq("rdio_stall_cycles", cnt, 5);
    io_in_valid = 1'b1; io_in_data = 8'h41;
    smp();
    check_eq("rdio_ready", io_in_ready, 1);
    check_eq("rdio_enable", core_enable, 1);
    cyc(); core_bus_op = BusNone; io_in_valid = 1'b0; smp();
    check_eq("rdio_ready_once", io_in_ready, 0);
    check_eq("rdio_value", core_val_in, 8'h41);

    // Two BusWriteIo with a blocked consumer
    cyc(); core_bus_op = BusWriteIo; core_val_out = 8'hA1; io_out_ready = 1'b0; smp();
    check_eq("wrio1_accept", core_enable, 1);
    cyc(); core_val_out = 8'hA2; smp();
    check_eq("wrio_head", io_out_data, 8'hA1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (!core_enable) cnt++;
      cyc(); smp();
    end
    check_eq("wrio2_stall_cycles", cnt, 3);
    cyc(); io_out_ready = 1'b1; smp();
    check_eq("wrio2_accept", core_enable, 1);
    cyc(); core_bus_op = BusNone; io_out_ready = 1'b0; smp();
    check_eq("wrio_second_valid", io_out_valid, 1);
    check_eq("wrio_second_data", io_out_data, 8'hA2);
    cyc(); io_out_ready = 1'b1; smp();
    cyc(); io_out_ready = 1'b0; smp();
    check_eq("wrio_empty", io_out_valid, 0);

    // Host request while running
`ifdef BF_HOST_SNOOP_EN
    cyc();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0001;
    core_bus_op = BusReadData; core_addr = 15'd0;
    smp();
    check_eq("snoop_core_stall", core_enable, 0);
    check_eq("snoop_mem_addr", mem_addr, 16'h0001);
    cyc(); smp();
    check_eq("snoop_ack", host_ack, 1);
    check_eq("snoop_rdata", host_rdata, 8'h2E);
    check_eq("snoop_core_resume", core_enable, 1);
    cyc(); host_req = 1'b0; core_bus_op = BusNone; smp();
    check_eq("snoop_core_read", core_val_in, 8'h01);
    do_halt();
`else
    cyc(); host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0001; smp();
    check_eq("run_no_host_re", mem_re, 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); smp();
      if (host_ack) acks++;
    end
    cyc(); core_halted = 1'b1; smp();
    if (host_ack) acks++;
    check_eq("run_no_host_ack", acks, 0);
    cyc(); core_halted = 1'b0; smp();
    check_eq("host_wait_done", state_out, DONE);
    check_eq("host_grant_done", mem_re, 1);
    cyc(); smp();
    check_eq("host_ack_done", host_ack, 1);
    check_eq("host_rdata_done", host_rdata, 8'h2E);
    cyc(); host_req = 1'b0; smp();
`endif

    // Abort during a stalled BusReadIo
    go_run();
    cyc(); core_bus_op = BusReadIo; io_in_valid = 1'b0; smp();
    saw_ready = io_in_ready;
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      saw_ready = saw_ready | io_in_ready;
    end
    cyc(); abort = 1'b1; smp();
    saw_ready = saw_ready | io_in_ready;
    cyc(); abort = 1'b0; core_bus_op = BusNone; smp();
    check_eq("abort_state", state_out, IDLE);
    check_eq("abort_core_reset", core_reset, 1);
    check_eq("abort_core_enable", core_enable, 0);
    check_eq("abort_no_ready", saw_ready, 0);

    // Reset in RUN with the output buffer full
    go_run();
    io_out_ready = 1'b0;
    core_op(BusWriteIo, 15'd0, 8'h55, rd, lat);
    check_eq("rst_run_buf_full", io_out_valid, 1);
    cyc(); reset = 1'b1; smp();
    cyc(); reset = 1'b0; smp();
    check_eq("rst_run_state", state_out, IDLE);
    check_eq("rst_run_out_valid", io_out_valid, 0);
    check_eq("rst_run_core_enable", core_enable, 0);

    // Randomized core ops against a memory/stream model
    for (int i = 0; i < 8; i++) begin
      prog_ref[i] = 8'($urandom);
      host_access(1'b1, 16'(i), prog_ref[i], rd, lat);
    end
    in_q.delete(); in_stream.delete(); exp_out.delete(); out_got.delete();
    for (int i = 0; i < 64; i++) begin
      in_stream.push_back(8'($urandom));
      in_q.push_back(in_stream[i]);
    end
    go_run();
    rand_env = 1'b1; mon_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      data_ref[a] = 8'($urandom);
      core_op(BusWriteData, 15'(a), data_ref[a], rd, lat);
    end
    k = 0;
    for (int n = 0; n < 80; n++) begin
      int sel, a;
      logic [7:0] v;
      sel = int'($urandom_range(0, 4));
      a   = int'($urandom_range(0, 15));
      v   = 8'($urandom);
      case (sel)
        0: begin
          core_op(BusReadProg, 15'(a % 8), 8'h00, rd, lat);
          check_eq("rnd_prog", rd, prog_ref[a % 8]);
        end
        1: begin
          core_op(BusReadData, 15'(a), 8'h00, rd, lat);
          check_eq("rnd_data", rd, data_ref[a]);
        end
        2: begin
          core_op(BusWriteData, 15'(a), v, rd, lat);
          data_ref[a] = v;
        end
        3: begin
          core_op(BusReadIo, 15'd0, 8'h00, rd, lat);
          check_eq("rnd_io_in", rd, (k < in_stream.size()) ? in_stream[k] : 8'h00);
          k++;
        end
        default: begin
          core_op(BusWriteIo, 15'd0, v, rd, lat);
          exp_out.push_back(v);
        end
      endcase
    end
    rand_env = 1'b0;
    cyc(); io_out_ready = 1'b1; io_in_valid = 1'b0; smp();
    repeat (3) begin cyc(); smp(); end
    mon_en = 1'b0;
    io_out_ready = 1'b0;
    check_eq("rnd_out_count", out_got.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < out_got.size(); i++)
      check_eq("rnd_out_byte", out_got[i], exp_out[i]);
    do_halt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
